blk_36d14b: RTL and testbench

WEIGHT_S_LOADER_WQ_WEIGHT_S_SUM_MMAP_WRITE_ISSUER -- requirements
Module: weight_s_loader_wq_weight_s_sum_mmap_write_issuer

---
 rtl/blk_36d14b_if.sv | 51 +++++
 rtl/blk_36d14b.sv | 91 +++++++++
 tb/tb_blk_36d14b.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/blk_36d14b_if.sv
// Command, write-data and m_axi write-channel bundle for the mmap write issuer.
// master = issuer side, slave = environment (command source, data source, AXI slave).
interface blk_36d14b_if #(
    parameter int BUS_ADDR_WIDTH  = 64,
    parameter int BUS_DATA_WIDTH  = 512,
    parameter int MAX_OUTSTANDING = 16
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [BUS_ADDR_WIDTH-1:0]   in_CMD_ADDR;
    logic [31:0]                 in_CMD_LEN;
    logic                        in_CMD_VALID;
    logic                        out_CMD_READY;

    logic [BUS_DATA_WIDTH-1:0]   in_DATA;
    logic                        in_DATA_VALID;
    logic                        out_DATA_READY;

    logic [BUS_ADDR_WIDTH-1:0]   out_HLS_AWADDR;
    logic [31:0]                 out_HLS_AWLEN;
    logic                        out_HLS_AWVALID;
    logic                        in_HLS_AWREADY;

    logic [BUS_DATA_WIDTH-1:0]   out_HLS_WDATA;
    logic [BUS_DATA_WIDTH/8-1:0] out_HLS_WSTRB;
    logic                        out_HLS_WVALID;
    logic                        in_HLS_WREADY;

    logic                        in_HLS_BVALID;
    logic                        out_HLS_BREADY;

    logic                        out_DONE_VALID;
    logic                        out_IDLE;
    logic [OW-1:0]               out_OUTSTANDING;

    modport master (
        input  in_CMD_ADDR, in_CMD_LEN, in_CMD_VALID, in_DATA, in_DATA_VALID,
               in_HLS_AWREADY, in_HLS_WREADY, in_HLS_BVALID,
        output out_CMD_READY, out_DATA_READY, out_HLS_AWADDR, out_HLS_AWLEN,
               out_HLS_AWVALID, out_HLS_WDATA, out_HLS_WSTRB, out_HLS_WVALID,
               out_HLS_BREADY, out_DONE_VALID, out_IDLE, out_OUTSTANDING
    );

    modport slave (
        output in_CMD_ADDR, in_CMD_LEN, in_CMD_VALID, in_DATA, in_DATA_VALID,
               in_HLS_AWREADY, in_HLS_WREADY, in_HLS_BVALID,
        input  out_CMD_READY, out_DATA_READY, out_HLS_AWADDR, out_HLS_AWLEN,
               out_HLS_AWVALID, out_HLS_WDATA, out_HLS_WSTRB, out_HLS_WVALID,
               out_HLS_BREADY, out_DONE_VALID, out_IDLE, out_OUTSTANDING
    );
endinterface

// File: rtl/blk_36d14b.sv
// mmap write issuer: turns {addr,len} commands plus a beat stream into m_axi AW/W
// bursts, tracking outstanding write responses and pulsing DONE per response.
module blk_36d14b #(
    parameter int BUS_ADDR_WIDTH  = 64,
    parameter int BUS_DATA_WIDTH  = 512,
    parameter int MAX_OUTSTANDING = 16
) (
    input logic           ACLK,
    input logic           ARESET,
    input logic           ACLK_EN,
    blk_36d14b_if.master  bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, AW, DATA} state_t;

    state_t                    state;
    logic                      live;
    logic [OW-1:0]             outstanding;
    logic [31:0]               beats;
    logic [31:0]               len_q;
    logic [BUS_ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]               awlen_q;
    logic                      awvalid_q;
    logic                      done_q;

    logic cmd_ready, cmd_fire, aw_fire, in_data, w_fire, b_fire;

    always_comb begin
        cmd_ready = live && ACLK_EN && (state == IDLE) && (outstanding < OW'(MAX_OUTSTANDING));
        cmd_fire  = cmd_ready && bus.in_CMD_VALID;
        aw_fire   = ACLK_EN && (state == AW) && awvalid_q && bus.in_HLS_AWREADY;
        in_data   = ACLK_EN && (state == DATA);
        w_fire    = in_data && bus.in_DATA_VALID && bus.in_HLS_WREADY;
        // A response with nothing outstanding is dropped rather than wrapping the count.
        b_fire    = ACLK_EN && live && bus.in_HLS_BVALID && (outstanding != '0);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= IDLE;
            live        <= 1'b0;
            outstanding <= '0;
            beats       <= '0;
            len_q       <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awvalid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else if (ACLK_EN) begin
            live        <= 1'b1;
            done_q      <= b_fire;
            outstanding <= outstanding + OW'(aw_fire) - OW'(b_fire);
            case (state)
                IDLE: if (cmd_fire && bus.in_CMD_LEN != 32'd0) begin
                    awaddr_q  <= bus.in_CMD_ADDR;
                    awlen_q   <= bus.in_CMD_LEN - 32'd1;
                    len_q     <= bus.in_CMD_LEN;
                    awvalid_q <= 1'b1;
                    state     <= AW;
                end
                AW: if (aw_fire) begin
                    awvalid_q <= 1'b0;
                    beats     <= len_q;
                    state     <= DATA;
                end
                DATA: if (w_fire) begin
                    beats <= beats - 32'd1;
                    if (beats == 32'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_bresp_underflow: assert property (@(posedge ACLK) disable iff (ARESET)
        (ACLK_EN && live && bus.in_HLS_BVALID) |-> (outstanding != '0));

    assign bus.out_CMD_READY   = cmd_ready;
    assign bus.out_HLS_AWADDR  = awaddr_q;
    assign bus.out_HLS_AWLEN   = awlen_q;
    assign bus.out_HLS_AWVALID = awvalid_q;
    assign bus.out_HLS_WDATA   = bus.in_DATA;
    assign bus.out_HLS_WSTRB   = '1;
    assign bus.out_HLS_WVALID  = in_data && bus.in_DATA_VALID;
    assign bus.out_DATA_READY  = in_data && bus.in_HLS_WREADY;
    assign bus.out_HLS_BREADY  = live;
    assign bus.out_DONE_VALID  = done_q;
    assign bus.out_IDLE        = (state == IDLE) && (outstanding == '0) && !done_q;
    assign bus.out_OUTSTANDING = outstanding;
endmodule

// File: tb/tb_blk_36d14b.sv
// Directed bench for the mmap write issuer: a cycle table for the basic burst and
// zero-length command, plus hand sequences for backpressure, outstanding limit and reset.
module tb_blk_36d14b;
    logic ACLK = 1'b0;
    logic ARESET;
    logic ACLK_EN;
    int   checks = 0;
    int   errors = 0;

    always #5 ACLK = ~ACLK;

    blk_36d14b_if #(.BUS_ADDR_WIDTH(32), .BUS_DATA_WIDTH(32), .MAX_OUTSTANDING(2)) bus ();

    blk_36d14b #(.BUS_ADDR_WIDTH(32), .BUS_DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .ACLK_EN(ACLK_EN), .bus(bus)
    );

    typedef struct {
        logic        cv;
        logic [31:0] ca;
        logic [31:0] cl;
        logic        dv;
        logic [31:0] d;
        logic        bv;
        logic        e_crdy;
        logic        e_awv;
        logic [31:0] e_awa;
        logic [31:0] e_awl;
        logic        e_wv;
        logic        e_drdy;
        logic        e_done;
        logic        e_idle;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cmd_ready"}, 64'(bus.out_CMD_READY), 64'd0);
        chk({tag, ".awvalid"},   64'(bus.out_HLS_AWVALID), 64'd0);
        chk({tag, ".awaddr"},    64'(bus.out_HLS_AWADDR), 64'd0);
        chk({tag, ".awlen"},     64'(bus.out_HLS_AWLEN), 64'd0);
        chk({tag, ".wvalid"},    64'(bus.out_HLS_WVALID), 64'd0);
        chk({tag, ".data_ready"},64'(bus.out_DATA_READY), 64'd0);
        chk({tag, ".done"},      64'(bus.out_DONE_VALID), 64'd0);
        chk({tag, ".bready"},    64'(bus.out_HLS_BREADY), 64'd0);
        chk({tag, ".outst"},     64'(bus.out_OUTSTANDING), 64'd0);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        // cv ca cl | dv d bv | crdy awv awa awl | wv drdy done idle
        tbl[0]  = '{1, 32'h1000, 4, 1, 32'hA0, 0, 1, 0, 32'h0,    0, 0, 0, 0, 1};
        tbl[1]  = '{0, 32'h0,    0, 1, 32'hA0, 0, 0, 1, 32'h1000, 3, 0, 0, 0, 0};
        tbl[2]  = '{0, 32'h0,    0, 1, 32'hA0, 0, 0, 0, 32'h1000, 3, 1, 1, 0, 0};
        tbl[3]  = '{0, 32'h0,    0, 1, 32'hA1, 0, 0, 0, 32'h1000, 3, 1, 1, 0, 0};
        tbl[4]  = '{0, 32'h0,    0, 1, 32'hA2, 0, 0, 0, 32'h1000, 3, 1, 1, 0, 0};
        tbl[5]  = '{0, 32'h0,    0, 1, 32'hA3, 0, 0, 0, 32'h1000, 3, 1, 1, 0, 0};
        tbl[6]  = '{0, 32'h0,    0, 1, 32'hA4, 1, 1, 0, 32'h1000, 3, 0, 0, 0, 0};
        tbl[7]  = '{0, 32'h0,    0, 0, 32'h0,  0, 1, 0, 32'h1000, 3, 0, 0, 1, 0};
        tbl[8]  = '{0, 32'h0,    0, 0, 32'h0,  0, 1, 0, 32'h1000, 3, 0, 0, 0, 1};
        tbl[9]  = '{1, 32'h2000, 0, 0, 32'h0,  0, 1, 0, 32'h1000, 3, 0, 0, 0, 1};
        tbl[10] = '{1, 32'h3000, 2, 0, 32'h0,  0, 1, 0, 32'h1000, 3, 0, 0, 0, 1};
        tbl[11] = '{0, 32'h0,    0, 0, 32'h0,  0, 0, 1, 32'h3000, 1, 0, 0, 0, 0};
        tbl[12] = '{0, 32'h0,    0, 1, 32'hB0, 0, 0, 0, 32'h3000, 1, 1, 1, 0, 0};
        tbl[13] = '{0, 32'h0,    0, 1, 32'hB1, 0, 0, 0, 32'h3000, 1, 1, 1, 0, 0};
        tbl[14] = '{0, 32'h0,    0, 0, 32'h0,  1, 1, 0, 32'h3000, 1, 0, 0, 0, 0};
        tbl[15] = '{0, 32'h0,    0, 0, 32'h0,  0, 1, 0, 32'h3000, 1, 0, 0, 1, 0};
        tbl[16] = '{0, 32'h0,    0, 0, 32'h0,  0, 1, 0, 32'h3000, 1, 0, 0, 0, 1};

        ARESET = 1'b1;
        ACLK_EN = 1'b1;
        bus.in_CMD_ADDR = '0;
        bus.in_CMD_LEN = '0;
        bus.in_CMD_VALID = 1'b0;
        bus.in_DATA = '0;
        bus.in_DATA_VALID = 1'b0;
        bus.in_HLS_AWREADY = 1'b1;
        bus.in_HLS_WREADY = 1'b1;
        bus.in_HLS_BVALID = 1'b0;

        repeat (2) step();
        chk_reset_vals("reset");
        ARESET = 1'b0;
        step();
        chk("post_reset.cmd_ready", 64'(bus.out_CMD_READY), 64'd1);
        chk("post_reset.idle",      64'(bus.out_IDLE), 64'd1);
        chk("post_reset.bready",    64'(bus.out_HLS_BREADY), 64'd1);

        // Basic 4-beat burst, then a zero-length command followed by a 2-beat burst.
        for (int i = 0; i < 17; i++) begin
            bus.in_CMD_VALID  = tbl[i].cv;
            bus.in_CMD_ADDR   = tbl[i].ca;
            bus.in_CMD_LEN    = tbl[i].cl;
            bus.in_DATA_VALID = tbl[i].dv;
            bus.in_DATA       = tbl[i].d;
            bus.in_HLS_BVALID = tbl[i].bv;
            settle();
            chk($sformatf("r%0d.cmd_ready", i),  64'(bus.out_CMD_READY),   64'(tbl[i].e_crdy));
            chk($sformatf("r%0d.awvalid", i),    64'(bus.out_HLS_AWVALID), 64'(tbl[i].e_awv));
            chk($sformatf("r%0d.awaddr", i),     64'(bus.out_HLS_AWADDR),  64'(tbl[i].e_awa));
            chk($sformatf("r%0d.awlen", i),      64'(bus.out_HLS_AWLEN),   64'(tbl[i].e_awl));
            chk($sformatf("r%0d.wvalid", i),     64'(bus.out_HLS_WVALID),  64'(tbl[i].e_wv));
            chk($sformatf("r%0d.data_ready", i), 64'(bus.out_DATA_READY),  64'(tbl[i].e_drdy));
            chk($sformatf("r%0d.done", i),       64'(bus.out_DONE_VALID),  64'(tbl[i].e_done));
            chk($sformatf("r%0d.idle", i),       64'(bus.out_IDLE),        64'(tbl[i].e_idle));
            chk($sformatf("r%0d.bready", i),     64'(bus.out_HLS_BREADY),  64'd1);
            chk($sformatf("r%0d.wstrb", i),      64'(bus.out_HLS_WSTRB),   64'hF);
            if (tbl[i].e_wv)
                chk($sformatf("r%0d.wdata", i),  64'(bus.out_HLS_WDATA),   64'(tbl[i].d));
            step();
        end

        // Outstanding limit of 2 with responses withheld, then AW and B in the same cycle.
        bus.in_CMD_VALID = 1'b1;
        bus.in_CMD_ADDR = 32'h5000;
        bus.in_CMD_LEN = 32'd1;
        bus.in_DATA_VALID = 1'b1;
        bus.in_DATA = 32'h55;
        bus.in_HLS_BVALID = 1'b0;
        settle(); chk("lim.t0.cmd_ready", 64'(bus.out_CMD_READY), 64'd1); step();
        settle(); chk("lim.t1.awvalid", 64'(bus.out_HLS_AWVALID), 64'd1); step();
        settle(); chk("lim.t2.wvalid", 64'(bus.out_HLS_WVALID), 64'd1); step();
        settle(); chk("lim.t3.cmd_ready", 64'(bus.out_CMD_READY), 64'd1);
        chk("lim.t3.outst", 64'(bus.out_OUTSTANDING), 64'd1); step();
        step();
        step();
        settle(); chk("lim.t6.cmd_ready", 64'(bus.out_CMD_READY), 64'd0);
        chk("lim.t6.outst", 64'(bus.out_OUTSTANDING), 64'd2); step();
        bus.in_HLS_BVALID = 1'b1;
        settle(); chk("lim.t7.cmd_ready", 64'(bus.out_CMD_READY), 64'd0); step();
        bus.in_HLS_BVALID = 1'b0;
        settle(); chk("lim.t8.cmd_ready", 64'(bus.out_CMD_READY), 64'd1);
        chk("lim.t8.done", 64'(bus.out_DONE_VALID), 64'd1);
        chk("lim.t8.outst", 64'(bus.out_OUTSTANDING), 64'd1); step();
        bus.in_CMD_VALID = 1'b0;
        bus.in_HLS_BVALID = 1'b1;
        settle(); chk("coin.t9.awvalid", 64'(bus.out_HLS_AWVALID), 64'd1); step();
        bus.in_HLS_BVALID = 1'b0;
        settle(); chk("coin.t10.outst", 64'(bus.out_OUTSTANDING), 64'd1);
        chk("coin.t10.done", 64'(bus.out_DONE_VALID), 64'd1);
        chk("coin.t10.wvalid", 64'(bus.out_HLS_WVALID), 64'd1); step();
        bus.in_HLS_BVALID = 1'b1;
        settle(); chk("coin.t11.cmd_ready", 64'(bus.out_CMD_READY), 64'd1); step();
        bus.in_HLS_BVALID = 1'b0;
        settle(); chk("coin.t12.outst", 64'(bus.out_OUTSTANDING), 64'd0);
        chk("coin.t12.done", 64'(bus.out_DONE_VALID), 64'd1); step();
        settle(); chk("coin.t13.idle", 64'(bus.out_IDLE), 64'd1); step();

        // AW backpressure for 5 cycles, two beats of an 8-beat burst, then reset.
        bus.in_CMD_VALID = 1'b1;
        bus.in_CMD_ADDR = 32'h4000;
        bus.in_CMD_LEN = 32'd8;
        bus.in_HLS_AWREADY = 1'b0;
        bus.in_DATA = 32'hC0;
        settle(); chk("stall.u0.cmd_ready", 64'(bus.out_CMD_READY), 64'd1); step();
        bus.in_CMD_VALID = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            settle();
            chk($sformatf("stall.u%0d.awvalid", k),    64'(bus.out_HLS_AWVALID), 64'd1);
            chk($sformatf("stall.u%0d.awaddr", k),     64'(bus.out_HLS_AWADDR), 64'h4000);
            chk($sformatf("stall.u%0d.awlen", k),      64'(bus.out_HLS_AWLEN), 64'd7);
            chk($sformatf("stall.u%0d.data_ready", k), 64'(bus.out_DATA_READY), 64'd0);
            step();
        end
        bus.in_HLS_AWREADY = 1'b1;
        settle(); chk("stall.u6.awvalid", 64'(bus.out_HLS_AWVALID), 64'd1); step();
        bus.in_DATA = 32'hC1;
        settle(); chk("rst.u7.wvalid", 64'(bus.out_HLS_WVALID), 64'd1);
        chk("rst.u7.wdata", 64'(bus.out_HLS_WDATA), 64'hC1); step();
        bus.in_DATA = 32'hC2;
        settle(); chk("rst.u8.wvalid", 64'(bus.out_HLS_WVALID), 64'd1); step();
        ARESET = 1'b1;
        step();
        settle(); chk_reset_vals("rst.u10");
        ARESET = 1'b0;
        step();
        settle(); chk("rst.u11.idle", 64'(bus.out_IDLE), 64'd1);
        chk("rst.u11.cmd_ready", 64'(bus.out_CMD_READY), 64'd1);
        for (int k = 11; k < 15; k++) begin
            settle();
            chk($sformatf("rst.u%0d.no_wvalid", k), 64'(bus.out_HLS_WVALID), 64'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
